// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline-stage register family.
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int unsigned OCC_W    = 2;

  // Valid bits of the stage encoded as {main, skid}; skid valid implies main valid.
  typedef enum logic [1:0] {
    VS_EMPTY = 2'b00,
    VS_MAIN  = 2'b10,
    VS_BOTH  = 2'b11
  } vstate_e;

  function automatic logic [OCC_W-1:0] occ_count(input logic m, input logic s);
    return {1'b0, m} + {1'b0, s};
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Handshake controller for one pipeline stage: tracks main/skid valid bits and
// produces the load enables and skid-to-main mux select for the datapath.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter bit SKID_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic stall,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic m_valid,
  output logic s_valid,
  output logic m_load,
  output logic m_sel_skid,
  output logic s_load,
  output logic clear
);

  vstate_e state, state_next;
  logic    acc, pop;

  assign m_valid = state[1];
  assign s_valid = state[0];

  // With the skid entry, ready depends only on registered state.
  assign in_ready = SKID_EN ? (~s_valid & ~stall)
                            : ((~m_valid | out_ready) & ~stall);

  assign acc = in_valid & in_ready & ~flush;
  assign pop = m_valid & out_ready & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) state <= VS_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    m_load     = 1'b0;
    m_sel_skid = 1'b0;
    s_load     = 1'b0;
    clear      = flush;
    if (flush) begin
      state_next = VS_EMPTY;
    end else begin
      // stall already forces acc=pop=0, so every branch below holds under stall.
      case (state)
        VS_EMPTY: begin
          if (acc) begin
            state_next = VS_MAIN;
            m_load     = 1'b1;
          end
        end
        VS_MAIN: begin
          if (pop) begin
            if (acc) m_load = 1'b1;
            else     state_next = VS_EMPTY;
          end else if (acc && SKID_EN) begin
            state_next = VS_BOTH;
            s_load     = 1'b1;
          end
        end
        VS_BOTH: begin
          if (pop) begin
            state_next = VS_MAIN;
            m_load     = 1'b1;
            m_sel_skid = 1'b1;
          end
        end
        default: state_next = VS_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional skid entry; flush
// turns held entries into RESET_VAL bubbles.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter bit                   SKID_EN   = 1'b1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [OCC_W-1:0] occ_o
);

  logic             m_valid, s_valid;
  logic             m_load, m_sel_skid, s_load, clear;
  logic [WIDTH-1:0] m_data, s_data;

  pipe_stage_ctrl #(.SKID_EN(SKID_EN)) u_ctrl (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (flush_i),
    .stall      (stall_i),
    .in_valid   (in_valid_i),
    .out_ready  (out_ready_i),
    .in_ready   (in_ready_o),
    .m_valid    (m_valid),
    .s_valid    (s_valid),
    .m_load     (m_load),
    .m_sel_skid (m_sel_skid),
    .s_load     (s_load),
    .clear      (clear)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear)  m_data <= RESET_VAL;
    else if (m_load)     m_data <= m_sel_skid ? s_data : in_data_i;
  end

  generate
    if (SKID_EN) begin : g_skid
      always_ff @(posedge clk_i) begin
        if (rst_i || clear) s_data <= RESET_VAL;
        else if (s_load)    s_data <= in_data_i;
      end
    end else begin : g_no_skid
      // s_load can never fire without a skid entry; the mux input is a constant.
      logic s_load_unused;
      assign s_load_unused = s_load;
      assign s_data        = RESET_VAL;
    end
  endgenerate

  assign out_valid_o = m_valid;
  assign out_data_o  = m_data;
  assign occ_o       = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid with and without the skid entry.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned W  = 32;
  localparam logic [31:0] RV = NOP_INST;

  logic        clk = 1'b0;
  logic        rst, flush, stall, in_valid, out_ready;
  logic [31:0] in_data;
  logic        rdy1, ov1, rdy0, ov0;
  logic [31:0] od1, od0;
  logic [1:0]  occ1, occ0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .SKID_EN(1'b1), .RESET_VAL(RV)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .occ_o(occ1)
  );

  pipe_stage_skid #(.WIDTH(W), .SKID_EN(1'b0), .RESET_VAL(RV)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0), .occ_o(occ0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(input logic v, input logic [1:0] occ,
                                       input logic rdy, input logic [31:0] data);
    return {28'h0, v, occ, rdy, (v ? data : 32'h0)};
  endfunction

  initial begin
    logic        er1, er0, pop1, pop0, acc1, acc0;
    logic [31:0] e1, e0;

    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_valid1", ov1, 0);  check("rst_data1", od1, RV);
    check("rst_occ1", occ1, 0);   check("rst_ready1", rdy1, 1);
    check("rst_valid0", ov0, 0);  check("rst_data0", od0, RV);
    check("rst_ready0", rdy0, 1);

    // Streaming: latency 1, one item per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + i;
      tick();
      check("stream1", {ov1, od1}, {1'b1, 32'hA0 + i});
      check("stream0", {ov0, od0}, {1'b1, 32'hA0 + i});
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain1", {ov1, occ1}, 3'b000);
    check("stream_drain0", {ov0, occ0}, 3'b000);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; tick();
    check("bp_occ_a", occ1, 1);
    in_data = 32'h22; tick();
    in_data = 32'h33; #1;
    check("bp_ready", rdy1, 0);
    check("bp_occ_b", occ1, 2);
    tick();
    check("bp_hold", {occ1, od1}, {2'd2, 32'h11});
    out_ready = 1'b1; tick();
    check("bp_out22", {ov1, occ1, od1}, {1'b1, 2'd1, 32'h22});
    check("bp_ready_back", rdy1, 1);
    tick();
    check("bp_out33", {ov1, occ1, od1}, {1'b1, 2'd1, 32'h33});
    in_valid = 1'b0; tick();
    check("bp_empty", {ov1, occ1}, 3'b000);

    // Flush with a full stage and a valid input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h31; tick();
    in_data = 32'h32; tick();
    check("fl_full", occ1, 2);
    in_data = 32'h44; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_state", {ov1, occ1, od1}, {1'b0, 2'd0, RV});
    check("fl_state0", {ov0, occ0, od0}, {1'b0, 2'd0, RV});
    out_ready = 1'b1; tick();
    check("fl_no44", {ov1, occ1}, 3'b000);

    // Stall freezes both sides
    in_valid = 1'b1; in_data = 32'h55; tick();
    check("st_load", {ov1, od1}, {1'b1, 32'h55});
    stall = 1'b1; in_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_ready1", rdy1, 0);
      check("st_ready0", rdy0, 0);
      tick();
      check("st_hold1", {ov1, occ1, od1}, {1'b1, 2'd1, 32'h55});
      check("st_hold0", {ov0, occ0, od0}, {1'b1, 2'd1, 32'h55});
    end
    flush = 1'b1; tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    check("st_flush_wins", {ov1, occ1, od1}, {1'b0, 2'd0, RV});

    // No-skid variant: ready passes through from downstream
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h61; tick();
    in_data = 32'h62; #1;
    check("ns_ready_full", rdy0, 1);
    tick();
    check("ns_bb", {ov0, occ0, od0}, {1'b1, 2'd1, 32'h62});
    out_ready = 1'b0; #1;
    check("ns_ready_blocked", rdy0, 0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    check("ns_empty", {ov0, occ0}, 3'b000);

    // Randomized run against reference FIFO models
    rst = 1'b1; tick(); rst = 1'b0;
    q1.delete(); q0.delete();
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      #1;
      er1 = (q1.size() < 2) && !stall;
      er0 = ((q0.size() == 0) || out_ready) && !stall;
      e1  = (q1.size() != 0) ? q1[0] : 32'h0;
      e0  = (q0.size() != 0) ? q0[0] : 32'h0;
      check("rand1", pack(ov1, occ1, rdy1, od1), pack(q1.size() != 0, 2'(q1.size()), er1, e1));
      check("rand0", pack(ov0, occ0, rdy0, od0), pack(q0.size() != 0, 2'(q0.size()), er0, e0));
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        pop1 = (q1.size() != 0) && out_ready && !stall;
        pop0 = (q0.size() != 0) && out_ready && !stall;
        acc1 = in_valid && er1;
        acc0 = in_valid && er0;
        if (pop1) void'(q1.pop_front());
        if (pop0) void'(q0.pop_front());
        if (acc1) q1.push_back(in_data);
        if (acc0) q0.push_back(in_data);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
